// File: rtl/fetch_hazard_stage.sv
// fetch_hazard_stage: instruction fetch plus IF/ID register with RAW-hazard
// stalling and a fixed three-bubble branch shadow.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   imem_addr       - fetch address to a combinational instruction memory
//   imem_data       - instruction word at imem_addr (same cycle)
//   branch_ctrl     - branch-taken flag from MEM (only looked at in BR2)
//   branch_target   - branch target from MEM
//   IDpc            - fetch address + 4 of the issued instruction, 0 on a bubble
//   IDinstruction   - issued instruction, 0 (nop) on a bubble
//   stall           - a valid ID instruction is held back by a hazard
module fetch_hazard_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        branch_ctrl,
  input  logic [31:0] branch_target,
  output logic [31:0] IDpc,
  output logic [31:0] IDinstruction,
  output logic        stall
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic [1:0] {RUN, BR1, BR2, BR3} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc4;
  logic [XLEN-1:0] ifid_instr;
  logic [RW-1:0]   p0, p1, p2;

  logic [5:0]      opcode;
  logic [RW-1:0]   src_a, src_b, dest;
  logic            is_branch;
  logic            hazard;
  logic            run_valid;
  logic            issue;
  logic [XLEN-1:0] pc_plus4;

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);
  assign opcode    = ifid_instr[31:26];

  // Register-usage decode of the instruction sitting in ID; unused slots read as $0.
  always_comb begin
    src_a     = '0;
    src_b     = '0;
    dest      = '0;
    is_branch = 1'b0;
    case (opcode)
      6'h00: begin
        src_a = ifid_instr[25:21];
        src_b = ifid_instr[20:16];
        dest  = ifid_instr[15:11];
      end
      6'h23: begin
        src_a = ifid_instr[25:21];
        dest  = ifid_instr[20:16];
      end
      6'h2B: begin
        src_a = ifid_instr[25:21];
        src_b = ifid_instr[20:16];
      end
      6'h04, 6'h05: begin
        src_a     = ifid_instr[25:21];
        src_b     = ifid_instr[20:16];
        is_branch = 1'b1;
      end
      6'h07: begin
        src_a     = ifid_instr[25:21];
        is_branch = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        src_a = ifid_instr[25:21];
        dest  = ifid_instr[20:16];
      end
      6'h0F: begin
        dest = ifid_instr[20:16];
      end
      default: ;
    endcase
  end

  // $0 is never a real dependency, so a zero source or zero entry never matches.
  function automatic logic src_busy(input logic [RW-1:0] r,
                                    input logic [RW-1:0] e0,
                                    input logic [RW-1:0] e1,
                                    input logic [RW-1:0] e2);
    return (r != '0) && ((r == e0) || (r == e1) || (r == e2));
  endfunction

  // Issue decision and ID-side outputs; everything is forced quiet during reset.
  always_comb begin
    hazard        = ifid_valid && (src_busy(src_a, p0, p1, p2) || src_busy(src_b, p0, p1, p2));
    run_valid     = !reset && (state == RUN) && ifid_valid;
    issue         = run_valid && !hazard;
    stall         = run_valid && hazard;
    IDpc          = issue ? ifid_pc4   : '0;
    IDinstruction = issue ? ifid_instr : '0;
  end

  // PC, IF/ID, branch-shadow state and pending-destination pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_pc4   <= '0;
      ifid_instr <= '0;
      state      <= RUN;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
    end else begin
      p2 <= p1;
      p1 <= p0;
      p0 <= issue ? dest : '0;
      case (state)
        RUN: begin
          if (!ifid_valid) begin
            ifid_valid <= 1'b1;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= imem_data;
            pc         <= pc_plus4;
          end else if (!hazard) begin
            if (is_branch) begin
              // PC is left on the fall-through address; BR2 may redirect it.
              ifid_valid <= 1'b0;
              state      <= BR1;
            end else begin
              ifid_pc4   <= pc_plus4;
              ifid_instr <= imem_data;
              pc         <= pc_plus4;
            end
          end
        end
        BR1: state <= BR2;
        BR2: begin
          if (branch_ctrl) pc <= branch_target;
          state <= BR3;
        end
        BR3: begin
          ifid_valid <= 1'b1;
          ifid_pc4   <= pc_plus4;
          ifid_instr <= imem_data;
          pc         <= pc_plus4;
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_hazard_stage.sv
// Directed bench for fetch_hazard_stage: straight-line fetch, RAW stalls,
// taken / not-taken branches, reset mid-branch, $0 writes and PC wrap.
module tb_fetch_hazard_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0020;

  localparam logic [31:0] ADDI1 = 32'h2001_0001;  // addi $1,$0,1
  localparam logic [31:0] ADDI2 = 32'h2002_0002;  // addi $2,$0,2
  localparam logic [31:0] ADDI3 = 32'h2003_0003;  // addi $3,$0,3
  localparam logic [31:0] ADDI4 = 32'h2004_0004;  // addi $4,$0,4
  localparam logic [31:0] ADDI7 = 32'h2007_0007;  // addi $7,$0,7
  localparam logic [31:0] ADDI8 = 32'h2008_0008;  // addi $8,$0,8
  localparam logic [31:0] ADDI9 = 32'h2009_0009;  // addi $9,$0,9
  localparam logic [31:0] ADD3  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] SUB4  = 32'h0061_2022;  // sub $4,$3,$1
  localparam logic [31:0] OR5   = 32'h0060_2825;  // or  $5,$3,$0
  localparam logic [31:0] BEQ   = 32'h1000_0033;  // beq $0,$0,...
  localparam logic [31:0] ADDI0 = 32'h2000_0001;  // addi $0,$0,1
  localparam logic [31:0] ADD1  = 32'h0000_0820;  // add $1,$0,$0

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        branch_ctrl;
  logic [31:0] branch_target;
  logic [31:0] id_pc, id_instr;
  logic        stall;

  logic [31:0] w_addr, w_pc, w_instr;
  logic        w_stall;

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_pass   = 0;

  fetch_hazard_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_ctrl(branch_ctrl), .branch_target(branch_target),
    .IDpc(id_pc), .IDinstruction(id_instr), .stall(stall)
  );

  fetch_hazard_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_data(32'h0),
    .branch_ctrl(1'b0), .branch_target(32'h0),
    .IDpc(w_pc), .IDinstruction(w_instr), .stall(w_stall)
  );

  always #5 clk = ~clk;

  // Instruction memory window at 0x0040_0000..0x0040_0FFF, nop elsewhere.
  always_comb imem_data = (imem_addr[31:12] == 20'h00400) ? mem[imem_addr[11:2]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a[11:2]] = d;
  endtask

  task automatic load_branch_prog();
    clear_mem();
    put(32'h0040_0020, ADDI1);
    put(32'h0040_0024, ADDI2);
    put(32'h0040_0028, ADDI3);
    put(32'h0040_002C, ADDI4);
    put(32'h0040_0030, BEQ);
    put(32'h0040_0034, ADDI7);
    put(32'h0040_0038, ADDI8);
    put(32'h0040_0100, ADDI9);
  endtask

  // One reset edge, checks, then release; returns in cycle 1 after release.
  task automatic do_reset(input string tag);
    reset         = 1'b1;
    branch_ctrl   = 1'b0;
    branch_target = 32'h0;
    step();
    check({tag, "_rst_addr"},  imem_addr, RST_PC);
    check({tag, "_rst_pc"},    id_pc, 32'h0);
    check({tag, "_rst_instr"}, id_instr, 32'h0);
    check({tag, "_rst_stall"}, 32'(stall), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog = '{ADDI1, ADDI2, ADDI3, ADDI4};
    reset         = 1'b1;
    branch_ctrl   = 1'b0;
    branch_target = 32'h0;

    // Straight-line code; plus PC wrap on the second instance.
    clear_mem();
    for (int k = 0; k < 4; k++) put(32'h0040_0020 + 32'(4 * k), prog[k]);
    do_reset("a");
    check("a_c1_pc", id_pc, 32'h0);
    check("a_c1_addr", imem_addr, 32'h0040_0020);
    check("wrap_c1_addr", w_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("a_instr%0d", k), id_instr, prog[k]);
      check($sformatf("a_pc%0d", k), id_pc, 32'h0040_0024 + 32'(4 * k));
      check($sformatf("a_addr%0d", k), imem_addr, 32'h0040_0024 + 32'(4 * k));
      check($sformatf("a_stall%0d", k), 32'(stall), 32'h0);
      if (k == 0) check("wrap_c2_addr", w_addr, 32'h0);
    end

    // add $3 then sub reading $3: three stall cycles, PC frozen.
    clear_mem();
    put(32'h0040_0020, ADD3);
    put(32'h0040_0024, SUB4);
    put(32'h0040_0028, ADDI4);
    do_reset("b");
    step();
    check("b_add", id_instr, ADD3);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("b_stall%0d", s), 32'(stall), 32'h1);
      check($sformatf("b_bub%0d", s), id_instr, 32'h0);
      check($sformatf("b_bubpc%0d", s), id_pc, 32'h0);
      check($sformatf("b_addr%0d", s), imem_addr, 32'h0040_0028);
    end
    step();
    check("b_sub", id_instr, SUB4);
    check("b_sub_pc", id_pc, 32'h0040_0028);
    check("b_sub_stall", 32'(stall), 32'h0);

    // add $3; nop; nop; or reading $3: one stall cycle.
    clear_mem();
    put(32'h0040_0020, ADD3);
    put(32'h0040_002C, OR5);
    do_reset("c");
    step();
    check("c_add", id_instr, ADD3);
    step();
    check("c_nop1_pc", id_pc, 32'h0040_0028);
    check("c_nop1_stall", 32'(stall), 32'h0);
    step();
    check("c_nop2_pc", id_pc, 32'h0040_002C);
    check("c_nop2_stall", 32'(stall), 32'h0);
    step();
    check("c_stall", 32'(stall), 32'h1);
    check("c_stall_pc", id_pc, 32'h0);
    step();
    check("c_or", id_instr, OR5);
    check("c_or_pc", id_pc, 32'h0040_0030);
    check("c_or_stall", 32'(stall), 32'h0);

    // Taken branch with stray branch_ctrl pulses in BR1 and BR3.
    load_branch_prog();
    do_reset("d");
    repeat (5) step();
    check("d_beq", id_instr, BEQ);
    check("d_beq_pc", id_pc, 32'h0040_0034);
    step();  // BR1
    check("d_br1_instr", id_instr, 32'h0);
    check("d_br1_stall", 32'(stall), 32'h0);
    check("d_br1_addr", imem_addr, 32'h0040_0034);
    branch_ctrl   = 1'b1;
    branch_target = 32'h0040_0200;
    step();  // BR2
    check("d_br2_addr", imem_addr, 32'h0040_0034);
    check("d_br2_stall", 32'(stall), 32'h0);
    branch_target = 32'h0040_0100;
    step();  // BR3
    check("d_br3_addr", imem_addr, 32'h0040_0100);
    check("d_br3_instr", id_instr, 32'h0);
    check("d_br3_stall", 32'(stall), 32'h0);
    branch_target = 32'h0040_0200;
    step();
    branch_ctrl = 1'b0;
    check("d_tgt", id_instr, ADDI9);
    check("d_tgt_pc", id_pc, 32'h0040_0104);
    check("d_tgt_addr", imem_addr, 32'h0040_0104);

    // Not-taken branch falls through to 0x00400034.
    load_branch_prog();
    do_reset("e");
    repeat (5) step();
    check("e_beq", id_instr, BEQ);
    repeat (3) step();
    check("e_br3_addr", imem_addr, 32'h0040_0034);
    check("e_br3_instr", id_instr, 32'h0);
    step();
    check("e_ft", id_instr, ADDI7);
    check("e_ft_pc", id_pc, 32'h0040_0038);

    // Reset during BR2 with branch_ctrl high, then $0-only dependencies.
    load_branch_prog();
    do_reset("f");
    repeat (7) step();  // now in BR2
    reset         = 1'b1;
    branch_ctrl   = 1'b1;
    branch_target = 32'h0040_0100;
    #1;
    check("f_rsthi_stall", 32'(stall), 32'h0);
    check("f_rsthi_pc", id_pc, 32'h0);
    @(negedge clk);
    step();
    check("f_rst_addr", imem_addr, RST_PC);
    check("f_rst_instr", id_instr, 32'h0);
    clear_mem();
    put(32'h0040_0020, ADDI0);
    put(32'h0040_0024, ADD1);
    reset       = 1'b0;
    branch_ctrl = 1'b0;
    check("f_c1_addr", imem_addr, 32'h0040_0020);
    step();
    check("f_addi0", id_instr, ADDI0);
    check("f_addi0_pc", id_pc, 32'h0040_0024);
    step();
    check("f_add1", id_instr, ADD1);
    check("f_add1_pc", id_pc, 32'h0040_0028);
    check("f_add1_stall", 32'(stall), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_stage.md
FETCH_HAZARD_STAGE -- requirements
Module: fetch_hazard_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0020, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  meaning the reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port imem_addr  output  32  meaning the fetch address to combinational instruction memory.
REQ-005 SHALL have port imem_data  input  32  meaning the instruction word at imem_addr, same cycle.
REQ-006 SHALL have port branch_ctrl  input  1  meaning the branch-taken flag from the MEM stage.
REQ-007 SHALL have port branch_target  input  32  meaning the branch target from the MEM stage (MEMpc).
REQ-008 SHALL have port IDpc  output  32  meaning fetch address + 4 of the issued instruction; 0 on a bubble.
REQ-009 SHALL have port IDinstruction  output  32  meaning the issued instruction; 32'h0 (nop) on a bubble.
REQ-010 SHALL have port stall  output  1  meaning high in any cycle that issues a bubble while ID holds a valid instruction.

Function
REQ-011 SHALL hold internal PC, IF/ID register {ifid_valid, ifid_pc4, ifid_instr}, state {RUN, BR1, BR2, BR3}, and three 5-bit pending-destination entries P0 (EX), P1 (MEM), P2 (WR).
REQ-012 SHALL drive imem_addr = PC combinationally.
REQ-013 SHALL decode the ID instruction by opcode [31:26]: 0x00 reads rs,rt, dest rd; 0x23 reads rs, dest rt; 0x2B reads rs,rt, no dest; 0x04/0x05 read rs,rt, no dest, branch; 0x07 reads rs, no dest, branch; 0x08-0x0E read rs, dest rt; 0x0F no reads, dest rt; any other opcode no reads, no dest.
REQ-014 SHALL treat register 0 as never read and never a destination.
REQ-015 SHALL raise hazard when ifid_valid and any read register equals a nonzero P0, P1 or P2.
REQ-016 In RUN with ifid_valid and no hazard: issue the ID instruction; load IF/ID with {1, PC+4, imem_data}; PC <= PC+4; if the issued instruction is a branch, clear ifid_valid instead and go to BR1.
REQ-017 In RUN with hazard: issue bubble, stall=1, hold PC and IF/ID.
REQ-018 In RUN with ifid_valid=0: issue bubble, stall=0, load IF/ID from imem_data, PC <= PC+4.
REQ-019 In BR1: issue bubble, hold PC, ifid_valid stays 0, go to BR2.
REQ-020 In BR2: issue bubble; if branch_ctrl then PC <= branch_target else hold PC; go to BR3.
REQ-021 In BR3: issue bubble, load IF/ID from imem_data at PC, PC <= PC+4, go to RUN.
REQ-022 SHALL ignore branch_ctrl outside BR2.
REQ-023 SHALL hold stall=0 in BR1-BR3.
REQ-024 SHALL shift each cycle: P2 <= P1, P1 <= P0, P0 <= issued dest (0 on bubble).
REQ-025 SHALL wrap PC modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
REQ-026 SHALL not stall longer than 3 consecutive cycles for one hazard.
REQ-027 SHALL complete one branch in exactly 3 bubble cycles after issue.
REQ-028 SHALL drive IDpc and IDinstruction combinationally from IF/ID and issue decision.

Reset
REQ-029 With reset high at a clock edge: PC <= RESET_PC, ifid_valid <= 0, state <= RUN, P0-P2 <= 0, regardless of state (including mid-branch or mid-stall).
REQ-030 While reset is high: IDinstruction=0, IDpc=0, stall=0.
REQ-031 First edge after reset release SHALL load IF/ID from RESET_PC; first valid issue in the following cycle.

Verification
REQ-032 Reset, then straight-line code -> imem_addr 0x00400020, 0x00400024, ...; instr at 0x00400020 issued in cycle 2 with IDpc 0x00400024; stall never asserted.
REQ-033 add $3,$1,$2 then sub $4,$3,$1 -> sub held with stall=1 for 3 cycles, 3 nops issued, sub issues in cycle 4; PC constant during stall.
REQ-034 add $3,.. ; nop ; nop ; or $5,$3,$0 -> or stalls 1 cycle (P2 match only).
REQ-035 beq at 0x00400030, branch_ctrl=1 with branch_target=0x00400100 in BR2 -> 3 bubbles, next issued IDpc 0x00400104; branch_ctrl pulse in BR1 or BR3 ignored.
REQ-036 beq with branch_ctrl=0 -> 3 bubbles, next issue is 0x00400034 (IDpc 0x00400038).
REQ-037 Reset asserted in BR2 with branch_ctrl=1 -> PC=RESET_PC, state RUN, no redirect; writes to $0 (addi $0,$0,1 then add $1,$0,$0) -> no stall.
